// File: rtl/pci_ad_sequencer_pkg.sv
// Shared types and constants for the PCI AD-bus sequencer.
package pci_ad_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CADDR = 3'd1,
    CDATA = 3'd2,
    CTURN = 3'd3,
    DADDR = 3'd4,
    DDATA = 3'd5,
    DTURN = 3'd6
  } seq_state_t;

  localparam logic PCI_DIR_TO_PCI   = 1'b1;
  localparam logic PCI_DIR_TO_AMIGA = 1'b0;

  // Bits needed to hold the values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pci_ad_sequencer_if.sv
// Bus bundle between the sequencer and the PCI/CPU/arbiter side.
// master = the sequencer, slave = the surrounding bus environment.
interface pci_ad_sequencer_if;
  logic CPU_REQn;
  logic CPU_RWn;
  logic DMA_GNTn;
  logic FRAMEn;
  logic IRDYn;
  logic TRDYn;
  logic STOPn;
  logic DEVSELn;
  logic PCICYCLEn;
  logic ADLATCH;
  logic ALATCH;
  logic PCI_DIR;
  logic AD_ENn;
  logic CPU_ACKn;
  logic CPU_RETRYn;
  logic CPU_ERRn;

  modport master (
    input  CPU_REQn, CPU_RWn, DMA_GNTn, FRAMEn, IRDYn, TRDYn, STOPn, DEVSELn,
    output PCICYCLEn, ADLATCH, ALATCH, PCI_DIR, AD_ENn, CPU_ACKn, CPU_RETRYn, CPU_ERRn
  );

  modport slave (
    output CPU_REQn, CPU_RWn, DMA_GNTn, FRAMEn, IRDYn, TRDYn, STOPn, DEVSELn,
    input  PCICYCLEn, ADLATCH, ALATCH, PCI_DIR, AD_ENn, CPU_ACKn, CPU_RETRYn, CPU_ERRn
  );
endinterface

// File: rtl/pci_ad_sequencer_cycle_counter.sv
// Loadable saturating up/down counter used for address-phase length,
// DEVSEL wait and target timeout.
module pci_cycle_counter #(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] LIMIT = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count
);

  // Clear beats load beats count; up stops at LIMIT, down stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      if (up) begin
        if (count != LIMIT) count <= count + WIDTH'(1);
      end else if (count != '0) begin
        count <= count - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/pci_ad_sequencer.sv
// PCI AD-bus sequencer: runs CPU-initiated PCI cycles and passes DMA
// addresses from external PCI masters onto the Amiga bus.
// Optional feature: `define PCI_TARGET_TIMEOUT_EN adds a target timeout
// that aborts CDATA once a claimed target stalls for 2**TO_WIDTH-1 clocks.
module pci_ad_sequencer
  import pci_ad_sequencer_pkg::*;
#(
  parameter int ADDR_CYCLES  = 1,
  parameter int DEVSEL_LIMIT = 5,
  parameter int TO_WIDTH     = 8
) (
  input logic                CLK40,
  input logic                RESETn,
  pci_ad_sequencer_if.master bus
);

  localparam int              AW          = 2;
  localparam int              DW          = cnt_width(DEVSEL_LIMIT);
  localparam logic [AW-1:0]   ADDR_LOAD   = AW'(ADDR_CYCLES - 1);
  localparam logic [DW-1:0]   DEVSEL_MAX  = DW'(DEVSEL_LIMIT);
  localparam logic [DW-1:0]   DEVSEL_LAST = DW'(DEVSEL_LIMIT - 1);

  if (ADDR_CYCLES < 1 || ADDR_CYCLES > 4 || DEVSEL_LIMIT < 1 || TO_WIDTH < 1) begin : g_param_check
    $error("pci_ad_sequencer: parameter out of range");
  end

  seq_state_t    state, state_nxt;
  logic          rd_q;       // latched CPU_RWn: 1 = read
  logic          claimed_q;  // a target has asserted DEVSELn in this CDATA
  logic [AW-1:0] addr_cnt;
  logic [DW-1:0] devsel_cnt;
  logic          dev_abort;
  logic          target_timeout;

  logic pcicycle_q, adlatch_q, alatch_q, pci_dir_q, ad_en_q, ack_q, retry_q, err_q;
  logic pcicycle_nxt, adlatch_nxt, alatch_nxt, pci_dir_nxt, ad_en_nxt, ack_nxt, retry_nxt, err_nxt;

  pci_cycle_counter #(.WIDTH(AW), .LIMIT({AW{1'b1}})) u_addr_cnt (
    .clk(CLK40), .rst_n(RESETn), .clr(1'b0), .load(state == IDLE), .load_val(ADDR_LOAD),
    .en(state == CADDR), .up(1'b0), .count(addr_cnt)
  );

  pci_cycle_counter #(.WIDTH(DW), .LIMIT(DEVSEL_MAX)) u_devsel_cnt (
    .clk(CLK40), .rst_n(RESETn), .clr(state_nxt == IDLE), .load(1'b0), .load_val('0),
    .en(state == CDATA), .up(1'b1), .count(devsel_cnt)
  );

  // Master abort: nobody claimed the cycle within DEVSEL_LIMIT CDATA clocks.
  assign dev_abort = (state == CDATA) && !claimed_q && bus.DEVSELn && (devsel_cnt == DEVSEL_LAST);

`ifdef PCI_TARGET_TIMEOUT_EN
  logic [TO_WIDTH-1:0] to_cnt;

  pci_cycle_counter #(.WIDTH(TO_WIDTH), .LIMIT({TO_WIDTH{1'b1}})) u_to_cnt (
    .clk(CLK40), .rst_n(RESETn), .clr(state_nxt == IDLE), .load(1'b0), .load_val('0),
    .en((state == CDATA) && (claimed_q || !bus.DEVSELn)), .up(1'b1), .count(to_cnt)
  );

  assign target_timeout = (state == CDATA) && claimed_q && (&to_cnt) && bus.TRDYn && bus.STOPn;
`else
  assign target_timeout = 1'b0;
`endif

  // State, latched direction, claim flag and registered outputs.
  always_ff @(posedge CLK40 or negedge RESETn) begin
    if (!RESETn) begin
      state      <= IDLE;
      rd_q       <= 1'b0;
      claimed_q  <= 1'b0;
      pcicycle_q <= 1'b1;
      adlatch_q  <= 1'b0;
      alatch_q   <= 1'b0;
      pci_dir_q  <= PCI_DIR_TO_AMIGA;
      ad_en_q    <= 1'b1;
      ack_q      <= 1'b1;
      retry_q    <= 1'b1;
      err_q      <= 1'b1;
    end else begin
      state      <= state_nxt;
      if (state == IDLE) rd_q <= bus.CPU_RWn;
      if (state == IDLE) claimed_q <= 1'b0;
      else if (state == CDATA && !bus.DEVSELn) claimed_q <= 1'b1;
      pcicycle_q <= pcicycle_nxt;
      adlatch_q  <= adlatch_nxt;
      alatch_q   <= alatch_nxt;
      pci_dir_q  <= pci_dir_nxt;
      ad_en_q    <= ad_en_nxt;
      ack_q      <= ack_nxt;
      retry_q    <= retry_nxt;
      err_q      <= err_nxt;
    end
  end

  // Next-state decode; DMA address phase wins over a simultaneous CPU request.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (!bus.FRAMEn && !bus.DMA_GNTn) state_nxt = DADDR;
        else if (!bus.CPU_REQn)           state_nxt = CADDR;
      end
      CADDR: if (addr_cnt == '0) state_nxt = CDATA;
      CDATA: if (!bus.TRDYn || !bus.STOPn || dev_abort || target_timeout) state_nxt = CTURN;
      CTURN: state_nxt = IDLE;
      DADDR: state_nxt = DDATA;
      DDATA: if (bus.FRAMEn && bus.IRDYn) state_nxt = DTURN;
      DTURN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the upcoming state so outputs line up with it.
  always_comb begin
    pcicycle_nxt = 1'b1;
    adlatch_nxt  = 1'b0;
    alatch_nxt   = 1'b0;
    pci_dir_nxt  = PCI_DIR_TO_AMIGA;
    ad_en_nxt    = 1'b1;
    ack_nxt      = 1'b1;
    retry_nxt    = 1'b1;
    err_nxt      = 1'b1;
    case (state_nxt)
      CADDR: begin
        pcicycle_nxt = 1'b0;
        ad_en_nxt    = 1'b0;
        pci_dir_nxt  = PCI_DIR_TO_PCI;
      end
      CDATA: begin
        pcicycle_nxt = 1'b0;
        if (!rd_q) begin
          ad_en_nxt   = 1'b0;
          pci_dir_nxt = PCI_DIR_TO_PCI;
        end else begin
          // First read data clock is the AD turnaround: keep the buffer off.
          ad_en_nxt = (state == CADDR);
        end
      end
      DADDR: adlatch_nxt = 1'b1;
      DDATA: begin
        alatch_nxt = 1'b1;
        ad_en_nxt  = bus.IRDYn && bus.TRDYn;
      end
      DTURN: alatch_nxt = 1'b1;
      default: ;
    endcase
    if (state == CDATA) begin
      if (!bus.TRDYn)                         ack_nxt   = 1'b0;
      else if (!bus.STOPn)                    retry_nxt = 1'b0;
      else if (dev_abort || target_timeout)   err_nxt   = 1'b0;
    end
  end

  assign bus.PCICYCLEn  = pcicycle_q;
  assign bus.ADLATCH    = adlatch_q;
  assign bus.ALATCH     = alatch_q;
  assign bus.PCI_DIR    = pci_dir_q;
  assign bus.AD_ENn     = ad_en_q;
  assign bus.CPU_ACKn   = ack_q;
  assign bus.CPU_RETRYn = retry_q;
  assign bus.CPU_ERRn   = err_q;

endmodule

// File: tb/tb_pci_ad_sequencer.sv
// Scoreboard bench for pci_ad_sequencer: stimulus queues the expected
// single-clock pulses (ACK/RETRY/ERR/ADLATCH) with their cycle numbers,
// a monitor pops and compares whenever a pulse appears.
module tb_pci_ad_sequencer;
  import pci_ad_sequencer_pkg::*;

  localparam int AC = 2;
  localparam int DL = 5;
  localparam int K_ACK = 1, K_RETRY = 2, K_ERR = 3, K_ADLATCH = 4, K_MULTI = 9;

  typedef struct { int kind; int at; } exp_t;
  exp_t exp_q[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic CLK40    = 1'b0;
  logic RESETn   = 1'b1;

  pci_ad_sequencer_if bus();

  pci_ad_sequencer #(.ADDR_CYCLES(AC), .DEVSEL_LIMIT(DL), .TO_WIDTH(8)) dut (
    .CLK40(CLK40), .RESETn(RESETn), .bus(bus)
  );

  always #5 CLK40 = ~CLK40;
  always @(posedge CLK40) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Monitor: every pulse must match the head of the expectation queue.
  initial begin
    int   nact;
    int   kind;
    exp_t e;
    forever begin
      @(negedge CLK40);
      if (RESETn) begin
        nact = int'(!bus.CPU_ACKn) + int'(!bus.CPU_RETRYn) + int'(!bus.CPU_ERRn) + int'(bus.ADLATCH);
        if (nact != 0) begin
          kind = !bus.CPU_ACKn ? K_ACK : !bus.CPU_RETRYn ? K_RETRY : !bus.CPU_ERRn ? K_ERR : K_ADLATCH;
          if (nact > 1) kind = K_MULTI;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pulse_unexpected: got kind %0d at cycle %0d, required no pulse", kind, cyc);
          end else begin
            e = exp_q.pop_front();
            if (kind != e.kind || cyc != e.at) begin
              n_fail++;
              $display("FAIL pulse: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                       kind, cyc, e.kind, e.at);
            end
          end
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK40);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: cycle %0d got %b required %b", name, cyc, act, req);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_PCICYCLEn"},  bus.PCICYCLEn,  1'b1);
    chk({tag, "_ADLATCH"},    bus.ADLATCH,    1'b0);
    chk({tag, "_ALATCH"},     bus.ALATCH,     1'b0);
    chk({tag, "_PCI_DIR"},    bus.PCI_DIR,    1'b0);
    chk({tag, "_AD_ENn"},     bus.AD_ENn,     1'b1);
    chk({tag, "_CPU_ACKn"},   bus.CPU_ACKn,   1'b1);
    chk({tag, "_CPU_RETRYn"}, bus.CPU_RETRYn, 1'b1);
    chk({tag, "_CPU_ERRn"},   bus.CPU_ERRn,   1'b1);
  endtask

  // One CPU cycle, starting from an IDLE clock. CDATA clock k (0 = entry)
  // carries DEVSELn low from dev_at, TRDYn low at trdy_at, STOPn low at
  // stop_at; the cycle terminates on the inputs of clock end_k, so the
  // pulse is seen in the following clock.
  task automatic cpu_cycle(input logic rd, input int dev_at, input int trdy_at, input int stop_at,
                           input int end_k, input int kind, input logic release_req);
    int c;
    bus.CPU_RWn  = rd;
    bus.CPU_REQn = 1'b0;
    c = cyc + AC + 1;
    exp_q.push_back('{kind, c + end_k + 1});
    for (int a = 0; a < AC; a++) begin
      tick();
      chk("caddr_PCICYCLEn", bus.PCICYCLEn, 1'b0);
      chk("caddr_PCI_DIR",   bus.PCI_DIR,   PCI_DIR_TO_PCI);
      chk("caddr_AD_ENn",    bus.AD_ENn,    1'b0);
    end
    for (int k = 0; k <= end_k; k++) begin
      tick();
      bus.DEVSELn = (dev_at >= 0 && k >= dev_at) ? 1'b0 : 1'b1;
      bus.TRDYn   = (k == trdy_at) ? 1'b0 : 1'b1;
      bus.STOPn   = (k == stop_at) ? 1'b0 : 1'b1;
      chk("cdata_PCICYCLEn", bus.PCICYCLEn, 1'b0);
      chk("cdata_PCI_DIR",   bus.PCI_DIR,   rd ? PCI_DIR_TO_AMIGA : PCI_DIR_TO_PCI);
      chk("cdata_AD_ENn",    bus.AD_ENn,    (rd && k == 0) ? 1'b1 : 1'b0);
    end
    tick();
    bus.TRDYn   = 1'b1;
    bus.STOPn   = 1'b1;
    bus.DEVSELn = 1'b1;
    if (release_req) bus.CPU_REQn = 1'b1;
    chk("cturn_PCICYCLEn", bus.PCICYCLEn, 1'b1);
    chk("cturn_AD_ENn",    bus.AD_ENn,    1'b1);
    tick();
    chk("idle_PCICYCLEn", bus.PCICYCLEn, 1'b1);
  endtask

  // DMA address phase arriving together with a CPU request.
  task automatic dma_then_cpu();
    int n0;
    bus.FRAMEn   = 1'b0;
    bus.DMA_GNTn = 1'b0;
    bus.CPU_RWn  = 1'b0;
    bus.CPU_REQn = 1'b0;
    n0 = cyc;
    exp_q.push_back('{K_ADLATCH, n0 + 1});
    tick();
    bus.IRDYn = 1'b0;
    chk("daddr_PCICYCLEn", bus.PCICYCLEn, 1'b1);
    chk("daddr_ALATCH",    bus.ALATCH,    1'b0);
    tick();
    bus.IRDYn = 1'b1;
    chk("ddata_ALATCH",  bus.ALATCH,  1'b1);
    chk("ddata_PCI_DIR", bus.PCI_DIR, PCI_DIR_TO_AMIGA);
    chk("ddata_AD_ENn_on", bus.AD_ENn, 1'b0);
    tick();
    bus.FRAMEn = 1'b1;
    chk("ddata_AD_ENn_off", bus.AD_ENn, 1'b1);
    chk("ddata_ALATCH2",    bus.ALATCH, 1'b1);
    tick();
    bus.DMA_GNTn = 1'b1;
    chk("dturn_ALATCH",    bus.ALATCH,    1'b1);
    chk("dturn_AD_ENn",    bus.AD_ENn,    1'b1);
    chk("dturn_PCICYCLEn", bus.PCICYCLEn, 1'b1);
    tick();
    chk("dma_idle_ALATCH",    bus.ALATCH,    1'b0);
    chk("dma_idle_PCICYCLEn", bus.PCICYCLEn, 1'b1);
    cpu_cycle(1'b0, 0, 1, -1, 1, K_ACK, 1'b1);
  endtask

  // Start a write and return in its first CDATA clock with DEVSELn low.
  task automatic enter_cdata(output int c);
    bus.CPU_RWn  = 1'b0;
    bus.CPU_REQn = 1'b0;
    c = cyc + AC + 1;
    tick(AC + 1);
    bus.CPU_REQn = 1'b1;
    bus.DEVSELn  = 1'b0;
  endtask

  task automatic long_wait_and_reset();
    int c;
    enter_cdata(c);
`ifdef PCI_TARGET_TIMEOUT_EN
    exp_q.push_back('{K_ERR, c + 256});
    tick(256);
    chk("timeout_cturn_PCICYCLEn", bus.PCICYCLEn, 1'b1);
    bus.DEVSELn = 1'b1;
    tick();
    enter_cdata(c);
`else
    tick(300);
    chk("cdata_wait_PCICYCLEn", bus.PCICYCLEn, 1'b0);
    chk("cdata_wait_AD_ENn",    bus.AD_ENn,    1'b0);
`endif
    tick();
    bus.TRDYn = 1'b0;
    #2 RESETn = 1'b0;
    #1 chk_reset("reset_in_cdata");
    bus.TRDYn   = 1'b1;
    bus.DEVSELn = 1'b1;
    @(posedge CLK40);
    #1 chk_reset("reset_held");
    #1 RESETn = 1'b1;
    tick(2);
    chk("post_reset_PCICYCLEn", bus.PCICYCLEn, 1'b1);
    chk("post_reset_CPU_ACKn",  bus.CPU_ACKn,  1'b1);
  endtask

  initial begin
    bus.CPU_REQn = 1'b1;
    bus.CPU_RWn  = 1'b1;
    bus.DMA_GNTn = 1'b1;
    bus.FRAMEn   = 1'b1;
    bus.IRDYn    = 1'b1;
    bus.TRDYn    = 1'b1;
    bus.STOPn    = 1'b1;
    bus.DEVSELn  = 1'b1;
    #3 RESETn = 1'b0;
    #1 chk_reset("por");
    tick(2);
    RESETn = 1'b1;
    tick(2);
    chk("idle_PCICYCLEn", bus.PCICYCLEn, 1'b1);

    cpu_cycle(1'b0,  1,  3, -1, 3,      K_ACK,   1'b1);  // write, ADDR_CYCLES=2
    cpu_cycle(1'b1,  0,  2, -1, 2,      K_ACK,   1'b1);  // read
    cpu_cycle(1'b0, -1, -1, -1, DL - 1, K_ERR,   1'b1);  // master abort
    cpu_cycle(1'b0,  0,  1,  1, 1,      K_ACK,   1'b1);  // TRDYn beats STOPn
    cpu_cycle(1'b1,  0, -1,  1, 1,      K_RETRY, 1'b0);  // retry, request kept
    cpu_cycle(1'b0,  2,  2, -1, 2,      K_ACK,   1'b1);  // back-to-back restart
    dma_then_cpu();
    long_wait_and_reset();

    tick(3);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pulses_missing: %0d expected pulses never seen, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
